bias_shift_pipe: RTL
====================

// Module: bias_shift_pipe
// PURPOSE
//  Multi-lane pipelined requantiser for the CNN accelerator output path: arithmetic right shift
//  of signed accumulator/bias words by a per-beat shift count, with optional round-half-up and
//  signed saturation to OUT_BITS. Sits between accumulator bank and activation/writeback;
//  valid/ready on both sides, 2-stage pipeline, full throughput.
// PARAMETERS
//  NUM_LANES  4   lanes processed per beat, all using the same shift count
//  DATA_BITS  48  signed input word width per lane
//  OUT_BITS   16  signed output word width per lane (OUT_BITS <= DATA_BITS)
//  SHIFT_W    5   width of n_shift
//  MIN_SHIFT  5   smallest legal shift count
//  MAX_SHIFT  25  largest legal shift count (MAX_SHIFT < DATA_BITS)
// PORTS
//  clk        in   1                   clock, rising edge
//  rstn       in   1                   asynchronous active-low reset
//  in_valid   in   1                   input beat valid
//  in_ready   out  1                   block accepts beat this cycle
//  d_in       in   NUM_LANES*DATA_BITS lane i at [i*DATA_BITS +: DATA_BITS], signed
//  n_shift    in   SHIFT_W             shift count, sampled with the beat
//  rnd_en     in   1                   1 = round-half-up, 0 = truncate (floor); sampled with beat
//  out_valid  out  1                   output beat valid
//  out_ready  in   1                   downstream accepts beat
//  d_out      out  NUM_LANES*OUT_BITS  lane i at [i*OUT_BITS +: OUT_BITS], signed
//  sat_flag   out  NUM_LANES           per-lane: this beat's lane was clipped
//  err_clr    in   1                   clears err_shift
//  err_shift  out  1                   sticky: a beat with illegal n_shift was accepted
// BEHAVIOUR
//  - Reset: in_ready=1 once rstn high; out_valid=0, d_out=0, sat_flag=0, err_shift=0; pipe empty.
//  - Transfer: input when in_valid&in_ready; output when out_valid&out_ready.
//  - Pipeline S1 (shift+round) -> S2 (saturate, output regs). Latency 2 cycles accept->out_valid.
//  - Advance: S2 loads when S2 empty or out_ready; S1 loads when S1 empty or S2 loads.
//    in_ready = !s1_valid | s2_load (combinational from out_ready; no skid). Bubbles collapse.
//  - Stall: out_valid held, d_out/sat_flag stable until out_ready; no beat dropped/duplicated.
//  - S1 math, per lane, in DATA_BITS+1 signed: x = sext(d_in);
//    rnd_en=1: y = (x + (1<<(n-1))) >>> n ; rnd_en=0: y = x >>> n (sign-fill, as floor).
//  - S2: y > 2^(OUT_BITS-1)-1 -> max, sat=1; y < -2^(OUT_BITS-1) -> min, sat=1; else y[OUT-1:0].
//  - Illegal n_shift (<MIN_SHIFT or >MAX_SHIFT): all lanes output 0, sat_flag=0, beat still
//    flows through with normal latency; err_shift set on acceptance.
//  - err_clr and illegal accept same cycle: err_shift stays 1 (set wins).
//  - Reset mid-operation: both stages flushed immediately, in-flight beats lost, err_shift=0.
//  - rnd_en and n_shift travel with the beat; changing them between beats has no effect
//    on beats already accepted.
// STRUCTURE
//  - Shared package/include: legal-shift range constants, lane slice macros, sat min/max consts.
//  - Sub-module lane_shift_round (combinational S1 per lane, DATA_BITS/SHIFT_W params),
//    instantiated NUM_LANES times via generate; saturation and handshake in top.
// TESTING
//  1 Truncate: d_in lane0=48'sd1000, n=5, rnd_en=0 -> d_out lane0=31, sat=0, 2 cycles later.
//  2 Round/neg: lane0=-48'sd48, n=5: rnd_en=1 -> -1; rnd_en=0 -> -2; lane0=48'sd48,rnd=1 -> 2.
//  3 Saturate: lane0=48'sh0000_1000_0000, n=5 -> 32767, sat_flag[0]=1;
//    negated -> -32768, sat_flag[0]=1; other lanes unaffected.
//  4 Backpressure: 10 back-to-back beats, out_ready toggling 1/0 randomly -> all 10 beats out
//    in order, values stable while stalled; in_ready=0 only when both stages full and stalled.
//  5 Illegal shift: n=3 then n=26 -> outputs 0, err_shift=1 after first; err_clr -> 0;
//    err_clr same cycle as illegal accept -> stays 1.
//  6 Reset mid-stream: rstn low with 2 beats in flight -> out_valid=0 immediately,
//    no stale beat after release; next beat n=MAX_SHIFT=25 on -1 -> -1 (trunc), 0 (rnd).

Source files
------------

// File: rtl/bias_shift_pipe_pkg.sv
// Shared constants for the bias/shift requantiser: default geometry and the legal shift window.
package bias_shift_pipe_pkg;

    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_DATA_BITS = 48;
    localparam int DEF_OUT_BITS  = 16;
    localparam int DEF_SHIFT_W   = 5;
    localparam int DEF_MIN_SHIFT = 5;
    localparam int DEF_MAX_SHIFT = 25;

endpackage

// File: rtl/bias_shift_pipe_lane_shift_round.sv
// One lane of the shift stage: sign-extend by one bit, optionally add the half-LSB bias,
// then arithmetic shift right so truncation behaves as floor for negative words.
module lane_shift_round
    import bias_shift_pipe_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int SHIFT_W   = DEF_SHIFT_W
) (
    input  logic signed [DATA_BITS-1:0] x,
    input  logic        [SHIFT_W-1:0]   n_shift,
    input  logic                        rnd_en,
    output logic signed [DATA_BITS:0]   y
);

    logic signed [DATA_BITS:0] xe;
    logic signed [DATA_BITS:0] bias;

    // The extra headroom bit keeps x + bias from wrapping at the top of the input range.
    always_comb begin
        xe   = {x[DATA_BITS-1], x};
        bias = '0;
        if (rnd_en && (n_shift != '0)) begin
            bias = (DATA_BITS+1)'(1) << (n_shift - SHIFT_W'(1));
        end
        y = (xe + bias) >>> n_shift;
    end

endmodule

// File: rtl/bias_shift_pipe.sv
// Multi-lane requantiser: S1 shifts/rounds each lane, S2 saturates into the output registers.
// Both stages advance with a valid/ready handshake and no skid buffer.
module bias_shift_pipe
    import bias_shift_pipe_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int OUT_BITS  = DEF_OUT_BITS,
    parameter int SHIFT_W   = DEF_SHIFT_W,
    parameter int MIN_SHIFT = DEF_MIN_SHIFT,
    parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*DATA_BITS-1:0] d_in,
    input  logic [SHIFT_W-1:0]             n_shift,
    input  logic                           rnd_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*OUT_BITS-1:0]  d_out,
    output logic [NUM_LANES-1:0]           sat_flag,
    input  logic                           err_clr,
    output logic                           err_shift
);

    localparam logic signed [DATA_BITS:0] SAT_MAX =
        {{(DATA_BITS-OUT_BITS+2){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [DATA_BITS:0] SAT_MIN =
        {{(DATA_BITS-OUT_BITS+2){1'b1}}, {(OUT_BITS-1){1'b0}}};

    logic s1_valid, s1_illegal, s2_valid;
    logic s1_load, s2_load, accept, illegal_in;
    logic [NUM_LANES-1:0][DATA_BITS:0]  lane_y;
    logic [NUM_LANES-1:0][DATA_BITS:0]  s1_y;
    logic [NUM_LANES-1:0][OUT_BITS-1:0] sat_val;
    logic [NUM_LANES-1:0][OUT_BITS-1:0] s2_data;
    logic [NUM_LANES-1:0]               sat_hit;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_shift_round #(
            .DATA_BITS(DATA_BITS),
            .SHIFT_W  (SHIFT_W)
        ) u_lane (
            .x      (d_in[i*DATA_BITS +: DATA_BITS]),
            .n_shift(n_shift),
            .rnd_en (rnd_en),
            .y      (lane_y[i])
        );
    end

    assign s2_load    = !s2_valid || out_ready;
    assign s1_load    = !s1_valid || s2_load;
    assign in_ready   = s1_load;
    assign accept     = in_valid && in_ready;
    assign illegal_in = (n_shift < SHIFT_W'(MIN_SHIFT)) || (n_shift > SHIFT_W'(MAX_SHIFT));
    assign out_valid  = s2_valid;
    assign d_out      = s2_data;

    // An illegal shift forces the whole beat to zero with no saturation reported.
    always_comb begin
        sat_val = '0;
        sat_hit = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!s1_illegal) begin
                if ($signed(s1_y[i]) > SAT_MAX) begin
                    sat_val[i] = SAT_MAX[OUT_BITS-1:0];
                    sat_hit[i] = 1'b1;
                end else if ($signed(s1_y[i]) < SAT_MIN) begin
                    sat_val[i] = SAT_MIN[OUT_BITS-1:0];
                    sat_hit[i] = 1'b1;
                end else begin
                    sat_val[i] = s1_y[i][OUT_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_y       <= '0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            sat_flag   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_y       <= lane_y;
                    s1_illegal <= illegal_in;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data  <= sat_val;
                    sat_flag <= sat_hit;
                end
            end
        end
    end

    // Setting on an illegal accept takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_shift <= 1'b0;
        end else if (accept && illegal_in) begin
            err_shift <= 1'b1;
        end else if (err_clr) begin
            err_shift <= 1'b0;
        end
    end

endmodule
